// File: rtl/adc_pkg.sv
// Shared definitions for the ADC acquisition path: FSM state encoding,
// trigger mode encodings and the sample/frame defaults used by the FIFO
// wrapper and the FFT-side reader.
package adc_pkg;

    localparam int ADC_DATA_W    = 12;
    localparam int ADC_FRAME_LEN = 2048;

    // Encoded values are exported on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TRIG = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_HANDOFF   = 3'd3
    } adc_state_e;

    typedef enum logic [1:0] {
        TRIG_FREE = 2'b00,
        TRIG_RISE = 2'b01,
        TRIG_FALL = 2'b10,
        TRIG_AUTO = 2'b11
    } trig_mode_e;

endpackage

// File: rtl/adc_trig_detect.sv
// Level trigger with hysteresis. The detector must first see the stream on
// the far side of the hysteresis band (armed) before a crossing of the level
// fires, so a stream that is already past the level never triggers.
module adc_trig_detect
    import adc_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W
) (
    input  logic              adc_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample,
    input  trig_mode_e        mode,
    input  logic [DATA_W-1:0] level,
    input  logic [DATA_W-1:0] hyst,
    input  logic              clear,
    output logic              fire
);

    logic              armed_q;
    logic              armed_d;
    logic [DATA_W-1:0] lo_thr;
    logic [DATA_W-1:0] hi_thr;
    logic [DATA_W:0]   hi_sum;
    logic              rise_mode;
    logic              fall_mode;
    logic              arm_cond;
    logic              fire_cond;

    // Saturating thresholds, arm/fire compares and next armed state.
    always_comb begin
        // NOTE: every variable gets a value on every path through this block
        // (defaults first), otherwise synthesis infers a latch.
        armed_d   = armed_q;
        lo_thr    = (hyst > level) ? '0 : level - hyst;
        hi_sum    = {1'b0, level} + {1'b0, hyst};
        hi_thr    = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];
        rise_mode = (mode == TRIG_RISE) || (mode == TRIG_AUTO);
        fall_mode = (mode == TRIG_FALL);
        arm_cond  = (rise_mode && (sample < lo_thr)) || (fall_mode && (sample > hi_thr));
        fire_cond = (rise_mode && (sample >= level)) || (fall_mode && (sample <= level));
        fire      = !clear && armed_q && fire_cond;
        if (clear || fire) begin
            armed_d = 1'b0;
        end else if (arm_cond) begin
            armed_d = 1'b1;
        end
    end

    // Armed flag register.
    always_ff @(posedge adc_clk or negedge rst) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!rst) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture sequencer: arm on start, wait for a level trigger (or timeout),
// write one decimated frame into the clock-crossing FIFO, then hold until
// the reader toggles its acknowledge.
module adc_capture_ctrl
    import adc_pkg::*;
#(
    parameter int DATA_W    = ADC_DATA_W,
    parameter int FRAME_LEN = ADC_FRAME_LEN,
    parameter int DECIM_W   = 8,
    parameter int TMO_W     = 24
) (
    input  logic               adc_clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  adc_in,
    input  logic               start,
    input  logic               abort,
    input  logic               cont,
    input  logic [DECIM_W-1:0] decim,
    input  logic [1:0]         trig_mode,
    input  logic [DATA_W-1:0]  trig_level,
    input  logic [DATA_W-1:0]  trig_hyst,
    input  logic [TMO_W-1:0]   trig_timeout,
    input  logic               fifo_full,
    input  logic               frame_ack_tgl,
    output logic               wr_en,
    output logic [DATA_W-1:0]  wr_data,
    output logic               frame_ready,
    output logic               busy,
    output logic [2:0]         state,
    output logic               forced_trig,
    output logic               overflow
);

    localparam int              CNT_W      = $clog2(FRAME_LEN) + 1;
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN);

    adc_state_e         state_q, state_d;
    logic               wr_en_q, wr_en_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               overflow_q, overflow_d;
    logic               frame_ready_q, frame_ready_d;
    logic [DECIM_W-1:0] decim_cnt_q, decim_cnt_d;
    logic [CNT_W-1:0]   samp_cnt_q, samp_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               ack_s1_q, ack_s2_q, ack_s3_q;

    trig_mode_e         mode;
    logic               trig_fire;
    logic               det_clear;
    logic               tmo_hit;
    logic               ack_edge;
    logic               write_slot;
    logic [DECIM_W-1:0] decim_max;
    logic [DECIM_W-1:0] decim_cur;
    logic [CNT_W-1:0]   samp_cur;

    assign mode      = trig_mode_e'(trig_mode);
    // Holding the detector cleared outside WAIT_TRIG drops the armed flag
    // on every entry into WAIT_TRIG.
    assign det_clear = (state_q != ST_WAIT_TRIG);
    assign tmo_hit   = (mode == TRIG_AUTO) && (tmo_cnt_q == trig_timeout);
    assign ack_edge  = ack_s2_q ^ ack_s3_q;
    assign decim_max = (decim == '0) ? '0 : decim - DECIM_W'(1);

    adc_trig_detect #(
        .DATA_W (DATA_W)
    ) u_trig_detect (
        .adc_clk (adc_clk),
        .rst     (rst),
        .sample  (adc_in),
        .mode    (mode),
        .level   (trig_level),
        .hyst    (trig_hyst),
        .clear   (det_clear),
        .fire    (trig_fire)
    );

    // Next-state, write-slot and counter logic for the capture FSM.
    always_comb begin
        state_d     = state_q;
        wr_en_d     = 1'b0;
        wr_data_d   = adc_in;
        overflow_d  = overflow_q;
        decim_cnt_d = decim_cnt_q;
        samp_cnt_d  = samp_cnt_q;
        tmo_cnt_d   = '0;
        write_slot  = 1'b0;
        decim_cur   = decim_cnt_q;
        samp_cur    = samp_cnt_q;
        forced_trig = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_WAIT_TRIG;
                    overflow_d = 1'b0;
                end
            end
            ST_WAIT_TRIG: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                // The trigger sample is the first write of the frame, so the
                // trigger cycle is itself write slot 0 of the capture.
                decim_cur = '0;
                samp_cur  = '0;
                if ((mode == TRIG_FREE) || trig_fire) begin
                    write_slot = 1'b1;
                end else if (tmo_hit) begin
                    write_slot  = 1'b1;
                    forced_trig = 1'b1;
                end
            end
            ST_CAPTURE: begin
                write_slot = (decim_cnt_q == '0);
            end
            ST_HANDOFF: begin
                if (ack_edge) begin
                    state_d = cont ? ST_WAIT_TRIG : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q == ST_CAPTURE) || write_slot) begin
            decim_cnt_d = (decim_cur == decim_max) ? '0 : decim_cur + DECIM_W'(1);
        end

        if (write_slot) begin
            if (fifo_full) begin
                // Truncate the frame rather than drop samples mid-frame.
                overflow_d = 1'b1;
                state_d    = ST_HANDOFF;
            end else begin
                wr_en_d    = 1'b1;
                samp_cnt_d = samp_cur + CNT_W'(1);
                state_d    = (samp_cnt_d == FRAME_LAST) ? ST_HANDOFF : ST_CAPTURE;
            end
        end

        if (abort) begin
            state_d     = ST_IDLE;
            wr_en_d     = 1'b0;
            overflow_d  = overflow_q;
            forced_trig = 1'b0;
        end

        // Low on the HANDOFF entry edge that carries the final write, so the
        // reader never sees ready before the last sample is in the FIFO.
        frame_ready_d = (state_d == ST_HANDOFF) && !wr_en_d;
    end

    // FSM state, write port and counter registers.
    always_ff @(posedge adc_clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            wr_en_q       <= 1'b0;
            wr_data_q     <= '0;
            overflow_q    <= 1'b0;
            frame_ready_q <= 1'b0;
            decim_cnt_q   <= '0;
            samp_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
            overflow_q    <= overflow_d;
            frame_ready_q <= frame_ready_d;
            decim_cnt_q   <= decim_cnt_d;
            samp_cnt_q    <= samp_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    // Two-flop synchronizer for the reader toggle plus the edge-detect flop;
    // it tracks the level in every state so stale toggles are absorbed.
    always_ff @(posedge adc_clk or negedge rst) begin
        if (!rst) begin
            ack_s1_q <= 1'b0;
            ack_s2_q <= 1'b0;
            ack_s3_q <= 1'b0;
        end else begin
            ack_s1_q <= frame_ack_tgl;
            ack_s2_q <= ack_s1_q;
            ack_s3_q <= ack_s2_q;
        end
    end

    // Abort gates the registered strobe so the FIFO sees no write in the
    // abort cycle itself.
    assign wr_en       = wr_en_q && !abort;
    assign wr_data     = wr_data_q;
    assign frame_ready = frame_ready_q;
    assign busy        = (state_q != ST_IDLE);
    assign state       = state_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with a 16-sample frame.
module tb_adc_capture_ctrl;

    localparam int DATA_W    = 12;
    localparam int FRAME_LEN = 16;
    localparam int DECIM_W   = 8;
    localparam int TMO_W     = 24;

    logic               adc_clk = 1'b0;
    logic               rst = 1'b0;
    logic [DATA_W-1:0]  adc_in = '0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               cont = 1'b0;
    logic [DECIM_W-1:0] decim = 8'd1;
    logic [1:0]         trig_mode = 2'b00;
    logic [DATA_W-1:0]  trig_level = '0;
    logic [DATA_W-1:0]  trig_hyst = '0;
    logic [TMO_W-1:0]   trig_timeout = '0;
    logic               fifo_full = 1'b0;
    logic               frame_ack_tgl = 1'b0;
    logic               wr_en;
    logic [DATA_W-1:0]  wr_data;
    logic               frame_ready;
    logic               busy;
    logic [2:0]         state;
    logic               forced_trig;
    logic               overflow;

    int checks = 0;
    int errors = 0;

    adc_capture_ctrl #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .DECIM_W   (DECIM_W),
        .TMO_W     (TMO_W)
    ) dut (
        .adc_clk       (adc_clk),
        .rst           (rst),
        .adc_in        (adc_in),
        .start         (start),
        .abort         (abort),
        .cont          (cont),
        .decim         (decim),
        .trig_mode     (trig_mode),
        .trig_level    (trig_level),
        .trig_hyst     (trig_hyst),
        .trig_timeout  (trig_timeout),
        .fifo_full     (fifo_full),
        .frame_ack_tgl (frame_ack_tgl),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .frame_ready   (frame_ready),
        .busy          (busy),
        .state         (state),
        .forced_trig   (forced_trig),
        .overflow      (overflow)
    );

    always #5 adc_clk = ~adc_clk;

    // Drive one sample for a full cycle; returns at the next falling edge.
    task automatic cyc(input logic [DATA_W-1:0] v);
        adc_in = v;
        @(negedge adc_clk);
    endtask

    task automatic pulse_start(input logic [DATA_W-1:0] v);
        start = 1'b1;
        cyc(v);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        cyc('0);
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d busy=%b, expected state=0 busy=0", state, busy);
        end
        checks++;
        if (wr_en !== 1'b0 || wr_data !== 12'd0) begin
            errors++;
            $display("FAIL reset_write: wr_en=%b wr_data=%0d, expected 0 and 0", wr_en, wr_data);
        end
        checks++;
        if (frame_ready !== 1'b0 || forced_trig !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ready=%b forced=%b ovf=%b, expected all 0",
                     frame_ready, forced_trig, overflow);
        end
        @(negedge adc_clk);
        rst = 1'b1;
        @(negedge adc_clk);
    endtask

    task automatic test_free_run();
        int n_wr;
        trig_mode = 2'b00;
        decim     = 8'd1;
        cont      = 1'b0;
        pulse_start(12'd100);
        checks++;
        if (state !== 3'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL free_arm: state=%0d busy=%b, expected state=1 busy=1", state, busy);
        end
        n_wr = 0;
        for (int i = 0; i < 24; i++) begin
            cyc(12'(200 + i));
            if (wr_en === 1'b1) begin
                checks++;
                if (wr_data !== 12'(200 + n_wr) || i != n_wr) begin
                    errors++;
                    $display("FAIL free_write%0d: data %0d in cycle %0d, expected %0d in cycle %0d",
                             n_wr, wr_data, i, 200 + n_wr, n_wr);
                end
                n_wr++;
            end
            if (i == 15) begin
                checks++;
                if (state !== 3'd3 || frame_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL free_last_edge: state=%0d ready=%b, expected state=3 ready=0",
                             state, frame_ready);
                end
            end
        end
        checks++;
        if (n_wr != FRAME_LEN) begin
            errors++;
            $display("FAIL free_count: got %0d writes, expected %0d", n_wr, FRAME_LEN);
        end
        checks++;
        if (frame_ready !== 1'b1 || busy !== 1'b1 || state !== 3'd3) begin
            errors++;
            $display("FAIL free_handoff: ready=%b busy=%b state=%0d, expected 1 1 3",
                     frame_ready, busy, state);
        end
        pulse_abort();
    endtask

    // Runs a trigger table; only the last entry may fire, writing exp_data.
    task automatic run_trig_table(input string name, input logic [1:0] mode,
                                  input int lvl, input int hys,
                                  input int tab[], input bit fire_last, input int exp_data);
        int early;
        trig_mode  = mode;
        trig_level = 12'(lvl);
        trig_hyst  = 12'(hys);
        decim      = 8'd1;
        pulse_start(12'(tab[0]));
        early = 0;
        for (int j = 0; j < tab.size(); j++) begin
            cyc(12'(tab[j]));
            if (j < tab.size() - 1 || !fire_last) begin
                if (wr_en !== 1'b0 || state !== 3'd1) early++;
            end
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL %s_no_early_fire: %0d bad cycles, expected 0", name, early);
        end
        if (fire_last) begin
            checks++;
            if (wr_en !== 1'b1 || wr_data !== 12'(exp_data) || state !== 3'd2) begin
                errors++;
                $display("FAIL %s_fire: wr_en=%b data=%0d state=%0d, expected 1 %0d 2",
                         name, wr_en, wr_data, state, exp_data);
            end
        end
        pulse_abort();
    endtask

    task automatic test_trigger();
        run_trig_table("rise", 2'b01, 2048, 64,
                       '{3000, 2900, 2500, 2100, 2050, 2000, 1984, 2100, 1983, 1990, 2047, 2048},
                       1'b1, 2048);
        run_trig_table("fall", 2'b10, 2048, 64,
                       '{1000, 2112, 2000, 2113, 2200, 2049, 2048}, 1'b1, 2048);
        run_trig_table("rise_sat", 2'b01, 30, 64, '{0, 0, 100, 5, 200}, 1'b0, 0);
        run_trig_table("fall_sat", 2'b10, 4090, 64, '{4095, 4095, 100, 4090}, 1'b0, 0);
    endtask

    task automatic test_timeout();
        int pulse_at;
        int n_pulse;
        int n_wr;
        trig_mode    = 2'b11;
        trig_level   = 12'd2048;
        trig_hyst    = 12'd64;
        trig_timeout = 24'd50;
        decim        = 8'd1;
        pulse_start(12'd100);
        pulse_at = -1;
        n_pulse  = 0;
        n_wr     = 0;
        for (int k = 0; k < 80; k++) begin
            if (forced_trig === 1'b1) begin
                n_pulse++;
                pulse_at = k;
            end
            if (wr_en === 1'b1) n_wr++;
            cyc(12'd100);
        end
        checks++;
        if (n_pulse != 1 || pulse_at != 50) begin
            errors++;
            $display("FAIL tmo_pulse: %0d pulses, last at cycle %0d, expected 1 at 50", n_pulse, pulse_at);
        end
        checks++;
        if (n_wr != FRAME_LEN || state !== 3'd3) begin
            errors++;
            $display("FAIL tmo_frame: %0d writes state=%0d, expected %0d writes state=3",
                     n_wr, state, FRAME_LEN);
        end
        pulse_abort();
    endtask

    task automatic test_decim();
        int dec_val[2] = '{4, 0};
        int gap_exp[2] = '{4, 1};
        int n_wr;
        int last;
        trig_mode = 2'b00;
        for (int c = 0; c < 2; c++) begin
            decim = 8'(dec_val[c]);
            pulse_start(12'd0);
            n_wr = 0;
            last = 0;
            for (int i = 0; i < 80; i++) begin
                cyc(12'(i));
                if (wr_en === 1'b1) begin
                    checks++;
                    if (wr_data !== 12'(i) || (n_wr > 0 && i - last != gap_exp[c]) || (n_wr == 0 && i != 0)) begin
                        errors++;
                        $display("FAIL decim%0d_write%0d: data %0d gap %0d, expected data %0d gap %0d",
                                 dec_val[c], n_wr, wr_data, i - last, i, gap_exp[c]);
                    end
                    last = i;
                    n_wr++;
                end
            end
            checks++;
            if (n_wr != FRAME_LEN) begin
                errors++;
                $display("FAIL decim%0d_count: %0d writes, expected %0d", dec_val[c], n_wr, FRAME_LEN);
            end
            pulse_abort();
        end
        decim = 8'd1;
    endtask

    task automatic test_overflow();
        int n_wr;
        trig_mode = 2'b00;
        decim     = 8'd1;
        pulse_start(12'd0);
        n_wr = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(12'(i));
            if (wr_en === 1'b1) n_wr++;
            if (n_wr == 5) fifo_full = 1'b1;
        end
        checks++;
        if (n_wr != 5 || overflow !== 1'b1 || state !== 3'd3 || frame_ready !== 1'b1) begin
            errors++;
            $display("FAIL ovf_truncate: writes=%0d ovf=%b state=%0d ready=%b, expected 5 1 3 1",
                     n_wr, overflow, state, frame_ready);
        end
        fifo_full = 1'b0;
        pulse_abort();
        checks++;
        if (overflow !== 1'b1 || state !== 3'd0) begin
            errors++;
            $display("FAIL ovf_keep_on_abort: ovf=%b state=%0d, expected 1 0", overflow, state);
        end
        pulse_start(12'd0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear_on_start: ovf=%b, expected 0", overflow);
        end
        pulse_abort();
    endtask

    task automatic test_ack();
        trig_mode = 2'b00;
        decim     = 8'd1;
        cont      = 1'b1;
        pulse_start(12'd0);
        for (int i = 0; i < 20; i++) cyc(12'(i));
        frame_ack_tgl = ~frame_ack_tgl;
        cyc('0);
        cyc('0);
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL ack_hold: state=%0d after 2 edges, expected 3", state);
        end
        cyc('0);
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL ack_cont: state=%0d after 3 edges, expected 1", state);
        end
        pulse_abort();
        cont = 1'b0;
        // Toggle while idle must be absorbed, not remembered.
        frame_ack_tgl = ~frame_ack_tgl;
        for (int i = 0; i < 5; i++) cyc('0);
        checks++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ack_idle: state=%0d busy=%b, expected 0 0", state, busy);
        end
        pulse_start(12'd0);
        for (int i = 0; i < 25; i++) cyc(12'(i));
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL ack_stale: state=%0d, expected 3", state);
        end
        // Ack with cont=0 and a coincident start: IDLE wins, start ignored.
        frame_ack_tgl = ~frame_ack_tgl;
        cyc('0);
        cyc('0);
        start = 1'b1;
        cyc('0);
        start = 1'b0;
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL ack_to_idle: state=%0d, expected 0", state);
        end
        cyc('0);
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL ack_start_ignored: state=%0d, expected 0", state);
        end
    endtask

    task automatic test_abort();
        trig_mode = 2'b00;
        decim     = 8'd1;
        pulse_start(12'd0);
        for (int i = 0; i < 3; i++) cyc(12'(i));
        checks++;
        if (wr_en !== 1'b1 || state !== 3'd2) begin
            errors++;
            $display("FAIL abort_pre: wr_en=%b state=%0d, expected 1 2", wr_en, state);
        end
        abort = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_wr_same_cycle: wr_en=%b, expected 0", wr_en);
        end
        cyc('0);
        abort = 1'b0;
        checks++;
        if (state !== 3'd0 || wr_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: state=%0d wr_en=%b busy=%b, expected 0 0 0", state, wr_en, busy);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_trigger();
        test_timeout();
        test_decim();
        test_overflow();
        test_ack();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
